obj_punch: RTL and testbench

OBJ_PUNCH -- requirements
Module: obj_punch

---
 rtl/obj_punch.sv | 167 ++++++++++++++++
 tb/tb_obj_punch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_punch.sv
// obj_punch: dumps a memory address range as object-format frame pairs (origin + data).
// Latency: one REQ cycle plus memory latency per word, then 2 frame cycles (4 after a gap) and one NEXT cycle.
// Backpressure: frame bytes are held stable until frame_ready; memory reads are held until mem_finished.
//
// Ports:
//   clk, btnCpuReset         - clock, synchronous active-low reset
//   start, start_addr/end_addr - dump request and inclusive bounds (taken only in IDLE)
//   read_enable/address      - memory read request, held until mem_finished
//   mem_finished/read_data/word_valid - memory response
//   frame_data/frame_valid/frame_ready - output byte stream with valid/ready handshake
//   busy, done, words_sent   - status
module obj_punch (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        start,
  input  logic [11:0] start_addr,
  input  logic [11:0] end_addr,
  output logic        read_enable,
  output logic [11:0] address,
  input  logic        mem_finished,
  input  logic [11:0] read_data,
  input  logic        word_valid,
  output logic [7:0]  frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        busy,
  output logic        done,
  output logic [12:0] words_sent
);

  typedef enum logic [2:0] {
    IDLE, REQ, ORG_HI, ORG_LO, DAT_HI, DAT_LO, NEXT, FIN
  } state_t;

  state_t      state_q;
  logic [11:0] cur_q;
  logic [11:0] end_q;
  logic [11:0] data_q;
  logic [11:0] address_q;
  logic        need_org_q;
  logic        read_enable_q;
  logic        frame_valid_q;
  logic [7:0]  frame_data_q;
  logic        busy_q;
  logic        done_q;
  logic [12:0] words_sent_q;

  logic [11:0] cur_d;
  logic        xfer;

  assign cur_d = cur_q + 12'd1;
  assign xfer  = frame_valid_q && frame_ready;

  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      state_q       <= IDLE;
      cur_q         <= 12'd0;
      end_q         <= 12'd0;
      data_q        <= 12'd0;
      address_q     <= 12'd0;
      need_org_q    <= 1'b1;
      read_enable_q <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= 8'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      words_sent_q  <= 13'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_q        <= start_addr;
            end_q        <= end_addr;
            need_org_q   <= 1'b1;
            words_sent_q <= 13'd0;
            if (start_addr > end_addr) begin
              // Empty range: finish without touching memory or the frame stream.
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q       <= REQ;
              busy_q        <= 1'b1;
              read_enable_q <= 1'b1;
              address_q     <= start_addr;
            end
          end
        end
        REQ: begin
          if (mem_finished) begin
            read_enable_q <= 1'b0;
            data_q        <= read_data;
            if (!word_valid) begin
              // A hole in memory breaks contiguity, so the next valid word needs a fresh origin.
              need_org_q <= 1'b1;
              state_q    <= NEXT;
            end else if (need_org_q) begin
              state_q       <= ORG_HI;
              frame_valid_q <= 1'b1;
              frame_data_q  <= {2'b01, cur_q[11:6]};
            end else begin
              // read_data used directly: data_q only becomes valid after this edge.
              state_q       <= DAT_HI;
              frame_valid_q <= 1'b1;
              frame_data_q  <= {2'b00, read_data[11:6]};
            end
          end
        end
        ORG_HI: begin
          if (xfer) begin
            state_q      <= ORG_LO;
            frame_data_q <= {2'b00, cur_q[5:0]};
          end
        end
        ORG_LO: begin
          if (xfer) begin
            need_org_q   <= 1'b0;
            state_q      <= DAT_HI;
            frame_data_q <= {2'b00, data_q[11:6]};
          end
        end
        DAT_HI: begin
          if (xfer) begin
            state_q      <= DAT_LO;
            frame_data_q <= {2'b00, data_q[5:0]};
          end
        end
        DAT_LO: begin
          if (xfer) begin
            words_sent_q  <= words_sent_q + 13'd1;
            frame_valid_q <= 1'b0;
            frame_data_q  <= 8'd0;
            state_q       <= NEXT;
          end
        end
        NEXT: begin
          // Stopping on equality before incrementing keeps cur from wrapping past 7777.
          if (cur_q == end_q) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cur_q         <= cur_d;
            address_q     <= cur_d;
            read_enable_q <= 1'b1;
            state_q       <= REQ;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign read_enable = read_enable_q;
  assign address     = address_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign words_sent  = words_sent_q;

endmodule

// File: tb/tb_obj_punch.sv
// tb_obj_punch: self-checking bench for obj_punch with a memory responder and frame sink.
// Latency: memory responds after a configurable number of wait cycles.
// Backpressure: frame_ready is driven randomly or held low for a directed stall.
module tb_obj_punch;

  logic        clk = 1'b0;
  logic        btnCpuReset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = 12'd0;
  logic [11:0] end_addr = 12'd0;
  logic        read_enable;
  logic [11:0] address;
  logic        mem_finished = 1'b0;
  logic [11:0] read_data = 12'd0;
  logic        word_valid = 1'b0;
  logic [7:0]  frame_data;
  logic        frame_valid;
  logic        frame_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [12:0] words_sent;

  obj_punch dut (
    .clk(clk), .btnCpuReset(btnCpuReset), .start(start),
    .start_addr(start_addr), .end_addr(end_addr),
    .read_enable(read_enable), .address(address),
    .mem_finished(mem_finished), .read_data(read_data), .word_valid(word_valid),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [4096];
  bit          vmem [4096];
  logic [7:0]  got [$];
  logic [11:0] reads [$];
  logic [7:0]  exp_q [$];
  int exp_words, exp_reads;
  int tests = 0, fails = 0;
  int done_cnt = 0, overlap_cnt = 0, stab_err = 0, busy_err = 0;
  int lat = 0, wait_cnt = 0, rdy_pct = 100, stall_idx = -1, stall_cnt = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = 8'd0;

  // Memory responder, frame sink and protocol monitors, all acting on the falling edge.
  always @(negedge clk) begin
    if (!btnCpuReset) begin
      mem_finished = 1'b0;
      wait_cnt = 0;
      prev_stall = 0;
      frame_ready = 1'b1;
    end else begin
      if (read_enable && frame_valid) overlap_cnt++;
      if (done) begin
        done_cnt++;
        if (busy) busy_err++;
      end
      if (prev_stall && (!frame_valid || frame_data != prev_data)) stab_err++;
      if (read_enable && !mem_finished) begin
        if (wait_cnt >= lat) begin
          mem_finished = 1'b1;
          read_data = mem[address];
          word_valid = vmem[address];
          reads.push_back(address);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_finished = 1'b0;
      end
      if (frame_valid && stall_idx == got.size() && stall_cnt < 5) begin
        frame_ready = 1'b0;
        stall_cnt++;
      end else begin
        frame_ready = ($urandom_range(99) < rdy_pct);
      end
      if (frame_valid && frame_ready) got.push_back(frame_data);
      prev_stall = frame_valid && !frame_ready;
      prev_data = frame_data;
    end
  end

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // Reference: walk the address range and emit pairs from the format rules.
  function automatic void build_model(int s, int e);
    bit need = 1;
    exp_q.delete();
    exp_words = 0;
    exp_reads = 0;
    if (s > e) return;
    for (int a = s; a <= e; a++) begin
      exp_reads++;
      if (vmem[a]) begin
        if (need) begin
          exp_q.push_back({2'b01, 6'(a / 64)});
          exp_q.push_back({2'b00, 6'(a % 64)});
        end
        exp_q.push_back({2'b00, mem[a][11:6]});
        exp_q.push_back({2'b00, mem[a][5:0]});
        exp_words++;
        need = 0;
      end else begin
        need = 1;
      end
    end
  endfunction

  task automatic fill(input int s, input int vmask);
    for (int a = 0; a < 4096; a++) begin
      mem[a] = 12'(a * 5 + 'o1234);
      vmem[a] = 1'b0;
    end
    for (int i = 0; i < 16; i++)
      if (vmask[i] && s + i < 4096) vmem[s + i] = 1'b1;
  endtask

  task automatic run_dump(input string tag, input int s, input int e, input bit extra);
    int n;
    got.delete();
    reads.delete();
    done_cnt = 0;
    stall_cnt = 0;
    build_model(s, e);
    @(posedge clk); #2;
    start_addr = 12'(s); end_addr = 12'(e); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    if (extra) begin
      @(posedge clk); #2;
      start_addr = 12'o0500; end_addr = 12'o0510; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk({tag, "_timeout"}, int'(n < 3000), 1);
    chk({tag, "_nframes"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_words"}, words_sent, exp_words);
    chk({tag, "_reads"}, reads.size(), exp_reads);
    for (int i = 0; i < reads.size(); i++)
      chk($sformatf("%s_raddr%0d", tag, i), reads[i], s + i);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  typedef struct {
    int s, e, vmask, lat, rdy, extra, exp_words, exp_frames;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] lit033 [6];

  initial begin
    int n;
    vecs[0] = '{s:'o0200, e:'o0201, vmask:'b11,    lat:0, rdy:100, extra:0, exp_words:2, exp_frames:6};
    vecs[1] = '{s:'o0200, e:'o0202, vmask:'b101,   lat:1, rdy:100, extra:0, exp_words:2, exp_frames:8};
    vecs[2] = '{s:'o7776, e:'o7777, vmask:'b11,    lat:0, rdy:100, extra:0, exp_words:2, exp_frames:6};
    vecs[3] = '{s:'o0100, e:'o0100, vmask:'b0,     lat:2, rdy:100, extra:0, exp_words:0, exp_frames:0};
    vecs[4] = '{s:'o0100, e:'o0103, vmask:'b1111,  lat:2, rdy:60,  extra:1, exp_words:4, exp_frames:10};
    vecs[5] = '{s:'o0040, e:'o0044, vmask:'b01110, lat:3, rdy:70,  extra:0, exp_words:3, exp_frames:8};
    lit033[0] = 8'o102; lit033[1] = 8'o000; lit033[2] = 8'o073;
    lit033[3] = 8'o000; lit033[4] = 8'o012; lit033[5] = 8'o005;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_read_enable", read_enable, 0);
    chk("rst_address", address, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_data", frame_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words_sent", words_sent, 0);
    @(posedge clk); #2;
    btnCpuReset = 1'b1;

    // Table-driven dumps
    for (int i = 0; i < 6; i++) begin
      fill(vecs[i].s, vecs[i].vmask);
      lat = vecs[i].lat;
      rdy_pct = vecs[i].rdy;
      run_dump($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].extra[0]);
      chk($sformatf("vec%0d_tbl_words", i), words_sent, vecs[i].exp_words);
      chk($sformatf("vec%0d_tbl_frames", i), got.size(), vecs[i].exp_frames);
    end

    // Known contents with a 5-cycle stall on the first data byte
    fill('o0200, 'b11);
    mem['o0200] = 12'o7300;
    mem['o0201] = 12'o1205;
    lat = 1; rdy_pct = 100; stall_idx = 2;
    run_dump("known", 'o0200, 'o0201, 0);
    stall_idx = -1;
    chk("known_stall_cycles", stall_cnt, 5);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("known_lit%0d", i), got[i], lit033[i]);

    // Empty range: done one cycle after start, no activity
    got.delete(); reads.delete(); done_cnt = 0;
    @(posedge clk); #2;
    start_addr = 12'o0300; end_addr = 12'o0200; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk); #1;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_read_enable", read_enable, 0);
    @(negedge clk); #1;
    chk("empty_done_low", done, 0);
    repeat (3) @(posedge clk);
    chk("empty_frames", got.size(), 0);
    chk("empty_reads", reads.size(), 0);
    chk("empty_done_pulses", done_cnt, 1);

    // Reset during ORG_LO, then a clean dump
    fill('o0200, 'b11);
    lat = 0; rdy_pct = 100;
    got.delete(); reads.delete();
    @(posedge clk); #2;
    start_addr = 12'o0200; end_addr = 12'o0201; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(frame_valid && got.size() == 2) && n < 100);
    chk("midrst_reached_org_lo", int'(n < 100), 1);
    btnCpuReset = 1'b0;
    @(negedge clk); #1;
    chk("midrst_frame_valid", frame_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_read_enable", read_enable, 0);
    chk("midrst_words_sent", words_sent, 0);
    @(posedge clk); #2;
    btnCpuReset = 1'b1;
    run_dump("postrst", 'o0200, 'o0201, 0);

    // Randomized dumps against the reference model
    for (int r = 0; r < 8; r++) begin
      int s, e;
      s = $urandom_range(4095);
      e = s + $urandom_range(12) - 1;
      if (e > 4095) e = 4095;
      for (int a = 0; a < 4096; a++) begin
        mem[a] = 12'($urandom);
        vmem[a] = ($urandom_range(99) < 65);
      end
      lat = $urandom_range(3);
      rdy_pct = $urandom_range(50, 100);
      run_dump($sformatf("rnd%0d", r), s, e, 0);
    end

    chk("never_read_and_frame", overlap_cnt, 0);
    chk("frame_stable_in_stall", stab_err, 0);
    chk("busy_low_on_done", busy_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
